// File: rtl/aux_arb_pkg.sv
// Shared definitions for the aux-bus arbiter: FSM state encoding and counter widths.
package aux_arb_pkg;

    localparam int BURST_W = 4;
    localparam int STATS_W = 16;

    localparam logic [1:0] ST_CPU  = 2'd0;
    localparam logic [1:0] ST_HOST = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/aux_arb_stats.sv
// Saturating activity counters for the aux-bus arbiter (built only with AUX_ARB_STATS_EN).
module aux_arb_stats
    import aux_arb_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               stall_i,
    input  logic               ack_i,
    output logic [STATS_W-1:0] stall_cnt_o,
    output logic [STATS_W-1:0] host_cnt_o
);

    logic [STATS_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STATS_W-1:0] host_cnt_q,  host_cnt_d;

    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v, input logic en);
        if (en && (v != {STATS_W{1'b1}}))
            return v + STATS_W'(1);
        return v;
    endfunction

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, stall_i);
        host_cnt_d  = sat_inc(host_cnt_q, ack_i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stall_cnt_q <= '0;
            host_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            host_cnt_q  <= host_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign host_cnt_o  = host_cnt_q;

endmodule

// File: rtl/aux_bus_arbiter.sv
// Shares the aux memory port between the risc16f84 core and a host master, freezing the core
// through cpu_clk_en_o while the host owns the port. Define AUX_ARB_STATS_EN for stall/ack counters.
module aux_bus_arbiter
    import aux_arb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic [AW-1:0] cpu_adr_i,
    input  logic [DW-1:0] cpu_dat_i,
    input  logic          cpu_we_i,
    input  logic          cpu_re_i,
    output logic [DW-1:0] cpu_dat_o,
    output logic          cpu_clk_en_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_adr_i,
    input  logic [DW-1:0] host_dat_i,
    output logic          host_gnt_o,
    output logic          host_ack_o,
    output logic [DW-1:0] host_dat_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [DW-1:0] mem_dat_o,
    output logic          mem_we_o,
    output logic          mem_re_o,
    input  logic [DW-1:0] mem_dat_i
`ifdef AUX_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] stall_cnt_o,
    output logic [STATS_W-1:0] host_cnt_o
`endif
);

    localparam logic [BURST_W-1:0] MAX_BURST_C = BURST_W'(MAX_BURST);

    logic [1:0]         state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [DW-1:0]      hdat_q,  hdat_d;

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        hdat_d  = hdat_q;
        case (state_q)
            ST_CPU: begin
                if (host_req_i)
                    state_d = ST_HOST;
            end
            ST_HOST: begin
                if (host_req_i) begin
                    if (!host_we_i)
                        hdat_d = mem_dat_i;
                    burst_d = burst_q + BURST_W'(1);
                    state_d = ST_ACK;
                end else begin
                    state_d = ST_CPU;
                    burst_d = '0;
                end
            end
            ST_ACK: begin
                // A full burst forces one CPU-enabled cycle before the next grant.
                if (host_req_i && (burst_q < MAX_BURST_C)) begin
                    state_d = ST_HOST;
                end else begin
                    state_d = ST_CPU;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = ST_CPU;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_CPU;
            burst_q <= '0;
            hdat_q  <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            hdat_q  <= hdat_d;
        end
    end

    always_comb begin
        cpu_clk_en_o = (state_q == ST_CPU);
        host_gnt_o   = (state_q == ST_HOST);
        host_ack_o   = (state_q == ST_ACK);
        if (state_q == ST_CPU) begin
            mem_adr_o = cpu_adr_i;
            mem_dat_o = cpu_dat_i;
            mem_we_o  = cpu_we_i;
            mem_re_o  = cpu_re_i;
        end else begin
            // Core strobes are dropped here: a frozen core never reaches memory.
            mem_adr_o = host_adr_i;
            mem_dat_o = host_dat_i;
            mem_we_o  = host_gnt_o & host_req_i & host_we_i;
            mem_re_o  = host_gnt_o & host_req_i & ~host_we_i;
        end
    end

    assign cpu_dat_o  = mem_dat_i;
    assign host_dat_o = hdat_q;

`ifdef AUX_ARB_STATS_EN
    aux_arb_stats u_stats (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .stall_i     (~cpu_clk_en_o),
        .ack_i       (host_ack_o),
        .stall_cnt_o (stall_cnt_o),
        .host_cnt_o  (host_cnt_o)
    );
`else
    // No activity counters in this build; arbitration is unaffected.
`endif

endmodule

// File: tb/tb_aux_bus_arbiter.sv
// Directed, table-driven bench for aux_bus_arbiter with a small byte-wide memory model.
module tb_aux_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_dat;
    logic        cpu_we, cpu_re;
    logic [7:0]  cpu_rdat;
    logic        cpu_clk_en;
    logic        host_req, host_we;
    logic [15:0] host_adr;
    logic [7:0]  host_dat;
    logic        host_gnt, host_ack;
    logic [7:0]  host_rdat;
    logic [15:0] mem_adr;
    logic [7:0]  mem_wdat;
    logic        mem_we, mem_re;
    logic [7:0]  mem_rdat;
`ifdef AUX_ARB_STATS_EN
    logic [15:0] stall_cnt, host_cnt;
`endif

    int total  = 0;
    int passed = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    aux_bus_arbiter #(.AW(16), .DW(8), .MAX_BURST(4)) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .cpu_adr_i    (cpu_adr),
        .cpu_dat_i    (cpu_dat),
        .cpu_we_i     (cpu_we),
        .cpu_re_i     (cpu_re),
        .cpu_dat_o    (cpu_rdat),
        .cpu_clk_en_o (cpu_clk_en),
        .host_req_i   (host_req),
        .host_we_i    (host_we),
        .host_adr_i   (host_adr),
        .host_dat_i   (host_dat),
        .host_gnt_o   (host_gnt),
        .host_ack_o   (host_ack),
        .host_dat_o   (host_rdat),
        .mem_adr_o    (mem_adr),
        .mem_dat_o    (mem_wdat),
        .mem_we_o     (mem_we),
        .mem_re_o     (mem_re),
        .mem_dat_i    (mem_rdat)
`ifdef AUX_ARB_STATS_EN
        ,
        .stall_cnt_o  (stall_cnt),
        .host_cnt_o   (host_cnt)
`endif
    );

    // Memory model: preloaded while reset is held, written on posedge.
    always @(posedge clk) begin
        if (!reset_n)
            mem[8'h10] <= 8'hC3;
        else if (mem_we)
            mem[mem_adr[7:0]] <= mem_wdat;
    end
    assign mem_rdat = mem[mem_adr[7:0]];

    typedef struct {
        logic [15:0] cadr; logic [7:0] cdat; logic cwe; logic cre;
        logic hreq; logic hwe; logic [15:0] hadr; logic [7:0] hdat;
        logic en; logic gnt; logic ack; logic mwe; logic mre;
        logic [15:0] madr; logic [7:0] mdat; logic [7:0] hrd;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(
        input logic [15:0] cadr, input logic [7:0] cdat, input logic cwe, input logic cre,
        input logic hreq, input logic hwe, input logic [15:0] hadr, input logic [7:0] hdat,
        input logic en, input logic gnt, input logic ack, input logic mwe, input logic mre,
        input logic [15:0] madr, input logic [7:0] mdat, input logic [7:0] hrd);
        vec_t v;
        v.cadr = cadr; v.cdat = cdat; v.cwe = cwe; v.cre = cre;
        v.hreq = hreq; v.hwe = hwe; v.hadr = hadr; v.hdat = hdat;
        v.en = en; v.gnt = gnt; v.ack = ack; v.mwe = mwe; v.mre = mre;
        v.madr = madr; v.mdat = mdat; v.hrd = hrd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        cpu_adr = '0; cpu_dat = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_adr = '0; host_dat = '0;
    endtask

    logic [44:0] act_v, exp_v;
    int acks;
    logic exp_en [15];
    logic exp_ack [15];

    initial begin
        //                cadr     cdat  we re  rq hw hadr     hdat   en g  a  mwe mre madr    mdat   hrd
        vecs[0]  = mk(16'h0000, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h00);
        vecs[1]  = mk(16'h1234, 8'h5A, 1, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 1, 0, 16'h1234, 8'h5A, 8'h00);
        vecs[2]  = mk(16'h1234, 8'h00, 0, 1, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 1, 16'h1234, 8'h00, 8'h00);
        vecs[3]  = mk(16'h0000, 8'h00, 0, 0, 1, 0, 16'h0010, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h00);
        vecs[4]  = mk(16'h0000, 8'h00, 0, 0, 1, 0, 16'h0010, 8'h00, 0, 1, 0, 0, 1, 16'h0010, 8'h00, 8'h00);
        vecs[5]  = mk(16'h0000, 8'h00, 0, 0, 0, 0, 16'h0010, 8'h00, 0, 0, 1, 0, 0, 16'h0010, 8'h00, 8'hC3);
        vecs[6]  = mk(16'h0000, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'hC3);
        vecs[7]  = mk(16'h0000, 8'h00, 0, 0, 1, 1, 16'h0020, 8'h77, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'hC3);
        vecs[8]  = mk(16'h00AA, 8'hEE, 1, 0, 1, 1, 16'h0020, 8'h77, 0, 1, 0, 1, 0, 16'h0020, 8'h77, 8'hC3);
        vecs[9]  = mk(16'h00AA, 8'hEE, 1, 0, 0, 1, 16'h0020, 8'h77, 0, 0, 1, 0, 0, 16'h0020, 8'h77, 8'hC3);
        vecs[10] = mk(16'h0000, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'hC3);
        vecs[11] = mk(16'h0000, 8'h00, 0, 0, 1, 0, 16'h0040, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'hC3);
        vecs[12] = mk(16'h0000, 8'h00, 0, 0, 0, 0, 16'h0040, 8'h00, 0, 1, 0, 0, 0, 16'h0040, 8'h00, 8'hC3);
        vecs[13] = mk(16'h0000, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'hC3);
        vecs[14] = mk(16'h0030, 8'h11, 1, 0, 1, 0, 16'h0030, 8'h00, 1, 0, 0, 1, 0, 16'h0030, 8'h11, 8'hC3);
        vecs[15] = mk(16'h0000, 8'h00, 0, 0, 1, 0, 16'h0030, 8'h00, 0, 1, 0, 0, 1, 16'h0030, 8'h00, 8'hC3);
        vecs[16] = mk(16'h0000, 8'h00, 0, 0, 0, 0, 16'h0030, 8'h00, 0, 0, 1, 0, 0, 16'h0030, 8'h00, 8'h11);
        vecs[17] = mk(16'h0000, 8'h00, 0, 0, 0, 0, 16'h0000, 8'h00, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 8'h11);

        // Expected (clk_en, ack) trace for six held host writes with MAX_BURST=4.
        exp_en  = '{1,0,0,0,0,0,0,0,0,1,0,0,0,0,1};
        exp_ack = '{0,0,1,0,1,0,1,0,1,0,0,1,0,1,0};

        reset_n = 1'b0;
        idle_inputs();
        #1;
        check("reset_outputs", {60'd0, cpu_clk_en, host_gnt, host_ack, |host_rdat}, {60'd0, 4'b1000});
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            cpu_adr = vecs[i].cadr; cpu_dat = vecs[i].cdat; cpu_we = vecs[i].cwe; cpu_re = vecs[i].cre;
            host_req = vecs[i].hreq; host_we = vecs[i].hwe; host_adr = vecs[i].hadr; host_dat = vecs[i].hdat;
            #1;
            act_v = {cpu_clk_en, host_gnt, host_ack, mem_we, mem_re, mem_adr, mem_wdat, host_rdat};
            exp_v = {vecs[i].en, vecs[i].gnt, vecs[i].ack, vecs[i].mwe, vecs[i].mre,
                     vecs[i].madr, vecs[i].mdat, vecs[i].hrd};
            check($sformatf("vec%0d", i), {19'd0, act_v}, {19'd0, exp_v});
        end

        @(negedge clk);
        idle_inputs();
        cpu_re = 1'b1; cpu_adr = 16'h1234;
        #1;
        check("cpu_read_1234", {56'd0, cpu_rdat}, {56'd0, 8'h5A});
        @(negedge clk);
        cpu_adr = 16'h0020;
        #1;
        check("cpu_read_host_write", {56'd0, cpu_rdat}, {56'd0, 8'h77});

        acks = 0;
        host_we = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            cpu_re = 1'b0;
            host_adr = 16'h0050 + 16'(acks);
            host_dat = 8'hA0 + 8'(acks);
            host_req = (acks < 6);
            #1;
            check($sformatf("burst_cyc%0d", c), {62'd0, cpu_clk_en, host_ack}, {62'd0, exp_en[c], exp_ack[c]});
            if (host_ack) begin
                acks++;
                if (acks >= 6)
                    host_req = 1'b0;
            end
        end

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            idle_inputs();
            cpu_re = 1'b1;
            cpu_adr = 16'h0050 + 16'(k);
            #1;
            check($sformatf("burst_data%0d", k), {56'd0, cpu_rdat}, {56'd0, 8'hA0 + 8'(k)});
        end

        @(negedge clk);
        idle_inputs();
        host_req = 1'b1; host_adr = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_ack", {63'd0, host_ack}, {63'd0, 1'b1});
        reset_n = 1'b0;
        #1;
        check("async_reset", {60'd0, cpu_clk_en, host_gnt, host_ack, |host_rdat}, {60'd0, 4'b1000});
`ifdef AUX_ARB_STATS_EN
        check("stats_reset", {32'd0, stall_cnt, host_cnt}, 64'd0);
`endif
        host_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_idle", {61'd0, cpu_clk_en, host_gnt, host_ack}, {61'd0, 3'b100});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
